// File: rtl/xbar_slave_port_arbiter.sv
// Per-slave crossbar front end: round-robin arbitration of NMASTERS masters onto one
// slave port, tid tagging, response steering and per-master outstanding-read limiting.
//
// state | meaning
// IDLE  | no grant held; arbitrate among eligible masters
// ISSUE | grant locked; request presented to slave until ack or withdrawal
module xbar_slave_port_arbiter #(
  parameter int NMASTERS  = 4,
  parameter int MAX_OUTST = 8,
  localparam int TW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1,
  localparam int CW = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NMASTERS-1:0]    m_req,
  input  logic [NMASTERS*32-1:0] m_addr,
  input  logic [NMASTERS-1:0]    m_cmd,
  input  logic [NMASTERS*32-1:0] m_wdata,
  output logic [NMASTERS-1:0]    m_ack,
  output logic [NMASTERS-1:0]    m_resp,
  output logic [31:0]            m_rdata,
  output logic                   slave_req,
  output logic [31:0]            slave_addr,
  output logic                   slave_cmd,
  output logic [TW-1:0]          slave_reqtid,
  output logic [31:0]            slave_wdata,
  input  logic                   slave_ack,
  input  logic [TW-1:0]          slave_resptid,
  input  logic [31:0]            slave_rdata,
  input  logic                   slave_resp,
  output logic [NMASTERS*CW-1:0] outst_cnt,
  output logic                   err_unexp_resp
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state_q;
  logic [TW-1:0] grant_q;
  logic [TW-1:0] rr_ptr_q;
  logic [CW-1:0] cnt_q [NMASTERS];
  logic          err_q;

  logic [NMASTERS-1:0] elig;
  logic [NMASTERS-1:0] inc;
  logic [NMASTERS-1:0] dec;
  logic                found;
  logic [TW-1:0]       pick;
  logic                issue;
  logic                xfer;
  logic                unexp;

  assign issue = (state_q == ISSUE);
  assign xfer  = slave_req & slave_ack;

  // Reads are throttled at the outstanding limit; writes never are.
  always_comb begin
    for (int i = 0; i < NMASTERS; i++) begin
      elig[i] = m_req[i] & (m_cmd[i] | (cnt_q[i] < CW'(MAX_OUTST)));
    end
  end

  // First eligible master at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NMASTERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NMASTERS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = TW'(idx);
      end
    end
  end

  assign slave_req    = issue & m_req[grant_q];
  assign slave_addr   = m_addr[int'(grant_q)*32 +: 32];
  assign slave_wdata  = m_wdata[int'(grant_q)*32 +: 32];
  assign slave_cmd    = m_cmd[grant_q];
  assign slave_reqtid = grant_q;
  assign m_rdata      = slave_rdata;

  // A response to a zero count is unexpected even if an accept lands the same cycle.
  always_comb begin
    unexp = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      m_ack[i]  = issue & (grant_q == TW'(i)) & slave_ack;
      inc[i]    = xfer & (grant_q == TW'(i)) & ~m_cmd[i];
      dec[i]    = slave_resp & (slave_resptid == TW'(i)) & (cnt_q[i] != '0);
      m_resp[i] = dec[i];
      unexp     = unexp | (slave_resp & (slave_resptid == TW'(i)) & (cnt_q[i] == '0));
      outst_cnt[i*CW +: CW] = cnt_q[i];
    end
  end

  assign err_unexp_resp = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NMASTERS; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_req[grant_q]) begin
            state_q <= IDLE;
          end else if (slave_ack) begin
            rr_ptr_q <= TW'((int'(grant_q) + 1) % NMASTERS);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      for (int i = 0; i < NMASTERS; i++) begin
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end

      if (unexp) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_slave_port_arbiter.sv
// Directed bench for xbar_slave_port_arbiter: a per-cycle vector table for a single
// read round trip, plus hand-written multi-cycle sequences for arbitration corners.
module tb_xbar_slave_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [3:0]   m_cmd;
  logic [127:0] m_wdata;
  logic [3:0]   m_ack;
  logic [3:0]   m_resp;
  logic [31:0]  m_rdata;
  logic         slave_req;
  logic [31:0]  slave_addr;
  logic         slave_cmd;
  logic [1:0]   slave_reqtid;
  logic [31:0]  slave_wdata;
  logic         slave_ack;
  logic [1:0]   slave_resptid;
  logic [31:0]  slave_rdata;
  logic         slave_resp;
  logic [15:0]  outst_cnt;
  logic         err_unexp_resp;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_c [4] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_0100, 32'h0000_01C0};
  logic [31:0] wd_c   [4] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};

  always #5 clk = ~clk;

  xbar_slave_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
    .slave_reqtid(slave_reqtid), .slave_wdata(slave_wdata),
    .slave_ack(slave_ack), .slave_resptid(slave_resptid),
    .slave_rdata(slave_rdata), .slave_resp(slave_resp),
    .outst_cnt(outst_cnt), .err_unexp_resp(err_unexp_resp)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  cmd;
    logic        ack;
    logic        rsp;
    logic [1:0]  rtid;
    logic        exp_sreq;
    logic [1:0]  exp_tid;
    logic [3:0]  exp_mack;
    logic [3:0]  exp_mresp;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    m_req = '0; m_cmd = '0; slave_ack = 1'b0;
    slave_resp = 1'b0; slave_resptid = '0; slave_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One arbitration cycle followed by one accepted issue cycle granting master g.
  task automatic xfer(input int g, input logic rsp, input logic [1:0] rtid);
    @(negedge clk);
    slave_resp = 1'b0;
    #1 chk("idle_slave_req", 32'(slave_req), 32'd0);
    @(negedge clk);
    slave_resp = rsp; slave_resptid = rtid;
    #1;
    chk("grant_req", 32'(slave_req), 32'd1);
    chk("grant_tid", 32'(slave_reqtid), 32'(g));
    chk("grant_addr", slave_addr, addr_c[g]);
    chk("grant_mack", 32'(m_ack), 32'(4'b0001 << g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_addr  = {addr_c[3], addr_c[2], addr_c[1], addr_c[0]};
    m_wdata = {wd_c[3], wd_c[2], wd_c[1], wd_c[0]};

    //           req      cmd      ack   rsp   rtid  sreq  tid   mack     mresp    cnt
    tbl[0] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'h0000};
    tbl[1] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0000, 4'b0000, 16'h0000};
    tbl[2] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 4'b0000, 16'h0000};
    tbl[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'h0100};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 4'b0100, 16'h0100};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 4'b0000, 16'h0000};

    // Reset state
    rst_n = 1'b0;
    m_req = 4'b1111; m_cmd = '0; slave_ack = 1'b1;
    slave_resp = 1'b0; slave_resptid = '0; slave_rdata = '0;
    @(negedge clk); #1;
    chk("rst_slave_req", 32'(slave_req), 32'd0);
    chk("rst_mack", 32'(m_ack), 32'd0);
    chk("rst_mresp", 32'(m_resp), 32'd0);
    chk("rst_cnt", 32'(outst_cnt), 32'd0);
    chk("rst_err", 32'(err_unexp_resp), 32'd0);

    // Single read round trip for master 2
    do_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      m_req = tbl[s].req; m_cmd = tbl[s].cmd; slave_ack = tbl[s].ack;
      slave_resp = tbl[s].rsp; slave_resptid = tbl[s].rtid; slave_rdata = 32'h8000_0100;
      #1;
      chk($sformatf("tbl%0d_sreq", s), 32'(slave_req), 32'(tbl[s].exp_sreq));
      chk($sformatf("tbl%0d_mack", s), 32'(m_ack), 32'(tbl[s].exp_mack));
      chk($sformatf("tbl%0d_mresp", s), 32'(m_resp), 32'(tbl[s].exp_mresp));
      chk($sformatf("tbl%0d_cnt", s), 32'(outst_cnt), 32'(tbl[s].exp_cnt));
      if (tbl[s].exp_sreq) begin
        chk($sformatf("tbl%0d_tid", s), 32'(slave_reqtid), 32'(tbl[s].exp_tid));
        chk($sformatf("tbl%0d_addr", s), slave_addr, addr_c[tbl[s].exp_tid]);
      end
      if (tbl[s].rsp) chk($sformatf("tbl%0d_rdata", s), m_rdata, 32'h8000_0100);
    end
    chk("tbl_err", 32'(err_unexp_resp), 32'd0);

    // Round robin with all masters reading
    do_reset();
    m_req = 4'b1111; m_cmd = 4'b0000; slave_ack = 1'b1;
    xfer(0, 1'b0, 2'd0);
    xfer(1, 1'b0, 2'd0);
    xfer(2, 1'b0, 2'd0);
    xfer(3, 1'b0, 2'd0);
    xfer(0, 1'b0, 2'd0);
    @(negedge clk); #1;
    chk("rr_cnt", 32'(outst_cnt), 32'h0000_1112);

    // Master 0 saturates at 8 outstanding reads; others still served
    do_reset();
    m_req = 4'b0001; m_cmd = 4'b0000; slave_ack = 1'b1;
    for (int n = 0; n < 8; n++) xfer(0, 1'b0, 2'd0);
    m_req = 4'b1111;
    xfer(1, 1'b0, 2'd0);
    chk("sat_cnt0", 32'(outst_cnt[3:0]), 32'd8);
    xfer(2, 1'b0, 2'd0);
    xfer(3, 1'b0, 2'd0);
    xfer(1, 1'b0, 2'd0);
    xfer(2, 1'b0, 2'd0);
    xfer(3, 1'b1, 2'd0);
    chk("sat_mresp", 32'(m_resp), 32'b0001);
    xfer(0, 1'b0, 2'd0);

    // Write at the read limit is not throttled and leaves the count alone
    do_reset();
    m_req = 4'b0010; m_cmd = 4'b0000; slave_ack = 1'b1;
    for (int n = 0; n < 8; n++) xfer(1, 1'b0, 2'd0);
    @(negedge clk); #1;
    chk("lim_read_blocked", 32'(slave_req), 32'd0);
    @(posedge clk); #1;
    chk("lim_read_blocked2", 32'(slave_req), 32'd0);
    chk("lim_cnt1", 32'(outst_cnt[7:4]), 32'd8);
    m_cmd = 4'b0010;
    xfer(1, 1'b0, 2'd0);
    chk("wr_cmd", 32'(slave_cmd), 32'd1);
    chk("wr_wdata", slave_wdata, wd_c[1]);
    @(posedge clk); #1;
    chk("wr_cnt1", 32'(outst_cnt[7:4]), 32'd8);

    // Slave stalls ack for 5 cycles: grant stays locked on master 3
    do_reset();
    m_req = 4'b1000; m_cmd = 4'b0000; slave_ack = 1'b0;
    @(negedge clk); #1;
    chk("stall_idle", 32'(slave_req), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_req = 4'b1001;
      #1;
      chk($sformatf("stall%0d_req", c), 32'(slave_req), 32'd1);
      chk($sformatf("stall%0d_tid", c), 32'(slave_reqtid), 32'd3);
      chk($sformatf("stall%0d_addr", c), slave_addr, addr_c[3]);
      chk($sformatf("stall%0d_mack", c), 32'(m_ack), 32'd0);
    end
    @(negedge clk);
    slave_ack = 1'b1;
    #1;
    chk("stall_done_tid", 32'(slave_reqtid), 32'd3);
    chk("stall_done_mack", 32'(m_ack), 32'b1000);
    xfer(0, 1'b0, 2'd0);

    // Request withdrawn before ack: no transfer, rr pointer unchanged
    do_reset();
    m_req = 4'b0100; m_cmd = 4'b0000; slave_ack = 1'b0;
    @(negedge clk); #1;
    chk("drop_idle", 32'(slave_req), 32'd0);
    @(negedge clk); #1;
    chk("drop_req", 32'(slave_req), 32'd1);
    m_req = 4'b0000;
    #1;
    chk("drop_req_low", 32'(slave_req), 32'd0);
    @(posedge clk); #1;
    m_req = 4'b1010; slave_ack = 1'b1;
    xfer(1, 1'b0, 2'd0);
    chk("drop_cnt2", 32'(outst_cnt[11:8]), 32'd0);

    // Unexpected response sets a sticky error cleared only by async reset
    do_reset();
    @(negedge clk);
    slave_resp = 1'b1; slave_resptid = 2'd1;
    #1;
    chk("unexp_mresp", 32'(m_resp), 32'd0);
    @(negedge clk);
    slave_resp = 1'b0;
    #1;
    chk("unexp_err", 32'(err_unexp_resp), 32'd1);
    chk("unexp_cnt", 32'(outst_cnt), 32'd0);
    repeat (3) @(negedge clk);
    #1 chk("unexp_sticky", 32'(err_unexp_resp), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("unexp_async_clr", 32'(err_unexp_resp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
